// File: rtl/ms_sched_pkg.sv
// Shared definitions for the millisecond delay scheduler: FSM state encoding,
// tick-rate derivation and a constant-width helper.
package ms_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int clog2(input longint unsigned value);
    int width;
    width = 1;
    for (int i = 1; i < 63; i++) begin
      if ((64'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic int ticks_per_ms(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the board clock down to a one-cycle tick every TICKS enabled cycles.
// load presets the counter so the first tick lands TICKS cycles after load.
module ms_prescaler #(
  parameter int TICKS = 50_000,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);

  assign tick = en && !load && (count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en) begin
      count <= (count == '0) ? RELOAD : count - 1'b1;
    end
  end

endmodule

// File: rtl/ms_delay_scheduler.sv
// Round-robin shared millisecond delay engine for N_REQ requesters.
// Define CANCEL_EN to add the cancel input that aborts a running delay.
module ms_delay_scheduler
  import ms_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int CLK_HZ = 50_000_000,
  parameter int MS_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*MS_W-1:0] ms_in,
`ifdef CANCEL_EN
  input  logic                  cancel,
`endif
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  aborted,
  output logic                  busy,
  output logic [MS_W-1:0]       ms_left
);

  localparam int TICKS = ticks_per_ms(CLK_HZ);
  localparam int CNT_W = clog2(TICKS);
  localparam int WIN_W = clog2(N_REQ);

  state_t           state, state_nxt;
  logic [WIN_W-1:0] winner, rr, pick;
  logic             pick_ok;
  logic             tick;
  logic             cancel_hit;
  logic [MS_W-1:0]  load_ms;
  logic [CNT_W-1:0] presc_count;
  logic             unused_presc;

  assign unused_presc = ^presc_count;
  assign load_ms      = ms_in[int'(winner) * MS_W +: MS_W];

  ms_prescaler #(
    .TICKS (TICKS),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .load  (state == ST_LOAD),
    .en    (state == ST_COUNT),
    .tick  (tick),
    .count (presc_count)
  );

`ifdef CANCEL_EN
  logic aborted_q;

  assign cancel_hit = (state == ST_COUNT) && cancel;
  assign aborted    = (state == ST_DONE) && aborted_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else if (state == ST_LOAD) begin
      aborted_q <= 1'b0;
    end else if (cancel_hit) begin
      aborted_q <= 1'b1;
    end
  end
`else
  assign cancel_hit = 1'b0;
  assign aborted    = 1'b0;
`endif

  // Search starts at the rr pointer and wraps, so the last winner goes to the back.
  always_comb begin
    int idx;
    idx     = 0;
    pick_ok = 1'b0;
    pick    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_ok && req[idx]) begin
        pick_ok = 1'b1;
        pick    = WIN_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (|req) state_nxt = ST_ARB;
      ST_ARB:   state_nxt = pick_ok ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nxt = (load_ms == '0) ? ST_DONE : ST_COUNT;
      ST_COUNT: if (cancel_hit || (tick && ms_left == MS_W'(1))) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      winner  <= '0;
      rr      <= '0;
      ms_left <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ARB && pick_ok) begin
        winner <= pick;
        rr     <= (pick == WIN_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
      end
      if (state == ST_LOAD) begin
        ms_left <= load_ms;
      end else if (state == ST_COUNT && tick) begin
        ms_left <= ms_left - 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    if (state == ST_LOAD || state == ST_COUNT || state == ST_DONE) grant[winner] = 1'b1;
    if (state == ST_DONE) done[winner] = 1'b1;
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ms_delay_scheduler.sv
// Randomized and directed bench for ms_delay_scheduler (10 kHz clock, 10 ticks/ms).
// Expected behaviour comes from a cycle-count model of the arbitration and delay rules.
module tb_ms_delay_scheduler;

  localparam int N_REQ  = 4;
  localparam int CLK_HZ = 10_000;
  localparam int MS_W   = 16;
  localparam int TPM    = CLK_HZ / 1000;

  logic                  clock;
  logic                  reset;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*MS_W-1:0] ms_in;
`ifdef CANCEL_EN
  logic                  cancel;
`endif
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      done;
  logic                  aborted;
  logic                  busy;
  logic [MS_W-1:0]       ms_left;

  int checksTotal;
  int checksPassed;
  int rrModel;

  ms_delay_scheduler #(
    .N_REQ  (N_REQ),
    .CLK_HZ (CLK_HZ),
    .MS_W   (MS_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .ms_in   (ms_in),
`ifdef CANCEL_EN
    .cancel  (cancel),
`endif
    .grant   (grant),
    .done    (done),
    .aborted (aborted),
    .busy    (busy),
    .ms_left (ms_left)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    else
      checksPassed++;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] newReq, input logic [N_REQ*MS_W-1:0] newMs);
    req   = newReq;
    ms_in = newMs;
  endtask

  function automatic logic [N_REQ*MS_W-1:0] randMs();
    logic [N_REQ*MS_W-1:0] v;
    for (int i = 0; i < N_REQ; i++) v[i*MS_W +: MS_W] = MS_W'($urandom_range(0, 4));
    return v;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_aborted"}, 32'(aborted), 32'd0);
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus('0, '0);
    #1;
    checkIdle("reset");
    checkOutput("reset_msLeft", 32'(ms_left), 32'd0);
    repeat (2) @(negedge clock);
    reset   = 1'b1;
    rrModel = 0;
  endtask

  // Called at the negedge of the IDLE cycle that samples a nonzero req (cycle 0).
  // Walks the whole transaction and checks every cycle against the timing rules.
  task automatic runTxn(input bit dropMid, output int winOut);
    int w;
    int msv;
    int dc;
    int idx;
    logic [N_REQ-1:0] wbit;
    w = -1;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (rrModel + k) % N_REQ;
      if (w < 0 && req[idx]) w = idx;
    end
    if (w < 0) w = 0;
    rrModel = (w + 1) % N_REQ;
    wbit    = N_REQ'(1) << w;
    msv     = int'(ms_in[w*MS_W +: MS_W]);
    dc      = 3 + msv * TPM;
    for (int k = 1; k <= dc; k++) begin
      @(negedge clock);
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("grant", 32'(grant), (k >= 2) ? 32'(wbit) : 32'd0);
      checkOutput("done", 32'(done), (k == dc) ? 32'(wbit) : 32'd0);
      checkOutput("msLeft", 32'(ms_left), (k >= 3) ? 32'(msv - (k - 3) / TPM) : 32'd0);
      checkOutput("aborted", 32'(aborted), 32'd0);
      if (dropMid && k == 4 && msv > 0) begin
        req[w] = 1'b0;
        ms_in  = {$urandom, $urandom};
      end
    end
    winOut = w;
  endtask

  initial begin
    int w;
    logic sawDone;
    logic [N_REQ-1:0] newReq;
    checksTotal  = 0;
    checksPassed = 0;
    rrModel      = 0;
    reset        = 1'b0;
    applyStimulus('0, '0);
`ifdef CANCEL_EN
    cancel = 1'b0;
`endif

    // Single requester, 3 ms.
    applyReset();
    applyStimulus(4'b0100, {16'd0, 16'd3, 16'd0, 16'd0});
    runTxn(1'b0, w);
    applyStimulus('0, '0);
    @(negedge clock);
    checkIdle("t1_after");
    checkOutput("t1_msLeftHeld", 32'(ms_left), 32'd0);

    // All requesting with 1 ms each: grants must rotate 0,1,2,3,0.
    applyReset();
    applyStimulus(4'b1111, {16'd1, 16'd1, 16'd1, 16'd1});
    for (int i = 0; i < 5; i++) begin
      runTxn(1'b0, w);
      @(negedge clock);
      checkIdle("t2_gap");
    end
    applyStimulus('0, '0);
    @(negedge clock);

    // Zero-length delay completes straight after LOAD.
    applyReset();
    applyStimulus(4'b0010, {16'd0, 16'd0, 16'd0, 16'd0});
    runTxn(1'b0, w);
    applyStimulus('0, '0);
    @(negedge clock);
    checkIdle("t3_after");

    // Requester drops and ms_in changes mid-count; original delay still completes.
    applyReset();
    applyStimulus(4'b0001, {16'd0, 16'd0, 16'd0, 16'd4});
    runTxn(1'b1, w);
    applyStimulus('0, '0);
    @(negedge clock);
    checkIdle("t6_after");

    // Reset asserted mid-delay drops it with no completion pulse.
    applyReset();
    applyStimulus(4'b0001, {16'd0, 16'd0, 16'd0, 16'd5});
    repeat (20) @(negedge clock);
    checkOutput("t4_busyBefore", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    checkIdle("t4_reset");
    checkOutput("t4_msLeft", 32'(ms_left), 32'd0);
    applyStimulus('0, '0);
    @(negedge clock);
    reset   = 1'b1;
    rrModel = 0;
    sawDone = 1'b0;
    repeat (70) begin
      @(negedge clock);
      sawDone = sawDone | (|done) | busy;
    end
    checkOutput("t4_noDoneAfterReset", 32'(sawDone), 32'd0);

`ifdef CANCEL_EN
    // Cancel during COUNT ends the delay on the next cycle with aborted set.
    applyReset();
    applyStimulus(4'b1000, {16'd100, 16'd0, 16'd0, 16'd0});
    repeat (25) @(negedge clock);
    checkOutput("t5_grantBefore", 32'(grant), 32'h8);
    checkOutput("t5_doneBefore", 32'(done), 32'd0);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    checkOutput("t5_done", 32'(done), 32'h8);
    checkOutput("t5_aborted", 32'(aborted), 32'd1);
    checkOutput("t5_grant", 32'(grant), 32'h8);
    applyStimulus('0, '0);
    @(negedge clock);
    checkIdle("t5_after");
`endif

    // Randomized traffic: masks, delays, mid-count drops and re-requests.
    applyReset();
    applyStimulus(4'($urandom_range(1, 15)), randMs());
    for (int t = 0; t < 30; t++) begin
      runTxn($urandom_range(0, 3) == 0, w);
      newReq = req & ~(N_REQ'(1) << w);
      if ($urandom_range(0, 1) == 1) newReq = newReq | 4'($urandom_range(0, 15));
      applyStimulus(newReq, randMs());
      @(negedge clock);
      checkIdle("rand_idle");
      checkOutput("rand_msLeftIdle", 32'(ms_left), 32'd0);
      if (req == '0) applyStimulus(4'($urandom_range(1, 15)), randMs());
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
